// File: rtl/sm_mul_seq.sv
// Sequential shift-add multiplier for sign-magnitude operands.
// Takes MAG_W add/shift steps plus one result-load cycle; the result waits in DONE until acked.
module sm_mul_seq #(
  parameter int MAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 A_s,
  input  logic [MAG_W-1:0]     A_m,
  input  logic                 B_s,
  input  logic [MAG_W-1:0]     B_m,
  output logic                 ready,
  output logic                 valid,
  input  logic                 ack,
  output logic [2*MAG_W-1:0]   P_m,
  output logic                 sf,
  output logic                 zf,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * MAG_W;
  localparam int CW = $clog2(MAG_W + 1);

  // Handshake: start is taken only on an edge where ready=1; the result is
  // consumed on an edge where valid=1 and ack=1. Both are ignored otherwise.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [MAG_W-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   p_q, p_d;
  logic            sf_q, sf_d;
  logic            zf_q, zf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      p_q      <= '0;
      sf_q     <= 1'b0;
      zf_q     <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      p_q      <= p_d;
      sf_q     <= sf_d;
      zf_q     <= zf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    p_d      = p_q;
    sf_d     = sf_q;
    zf_d     = zf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = PW'(A_m);
          mplier_d = B_m;
          sign_d   = A_s ^ B_s;
          acc_d    = '0;
          cnt_d    = CW'(MAG_W);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CW'(1);
        end else begin
          // Sign is masked by the zero test so negative zero never appears.
          p_d     = acc_q;
          zf_d    = (acc_q == '0);
          sf_d    = sign_q & (acc_q != '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign valid     = (state_q == DONE);
  assign P_m       = p_q;
  assign sf        = sf_q;
  assign zf        = zf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sm_mul_seq.sv
// Directed bench for sm_mul_seq: a 2-bit-magnitude instance for the main
// scenarios and a 4-bit-magnitude instance for wide products and busy time.
module tb_sm_mul_seq;

  logic       clk;
  logic       rst_n;
  logic       start, a_s, b_s, ack;
  logic [1:0] a_m, b_m;
  logic       ready, valid, sf, zf;
  logic [3:0] p_m;
  logic [1:0] dbg;

  logic       start4, a_s4, b_s4, ack4;
  logic [3:0] a_m4, b_m4;
  logic       ready4, valid4, sf4, zf4;
  logic [7:0] p_m4;
  logic [1:0] dbg4;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  sm_mul_seq #(.MAG_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A_s(a_s), .A_m(a_m),
    .B_s(b_s), .B_m(b_m), .ready(ready), .valid(valid), .ack(ack),
    .P_m(p_m), .sf(sf), .zf(zf), .dbg_state(dbg)
  );

  sm_mul_seq #(.MAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A_s(a_s4), .A_m(a_m4),
    .B_s(b_s4), .B_m(b_m4), .ready(ready4), .valid(valid4), .ack(ack4),
    .P_m(p_m4), .sf(sf4), .zf(zf4), .dbg_state(dbg4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one request into the MAG_W=2 instance and check its result.
  task automatic run_op(input bit as_, input logic [1:0] am, input bit bs_,
                        input logic [1:0] bm, input bit scramble, input bit do_ack,
                        input logic [3:0] exp_p, input bit exp_s, input bit exp_z);
    int lat;
    logic [5:0] e;
    exp_q.push_back({exp_z, exp_s, exp_p});
    a_s = as_; a_m = am; b_s = bs_; b_m = bm;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      a_s = 1'b1; a_m = 2'd0; b_s = 1'b1; b_m = 2'd0;
    end
    check("ready_drop", ready, 0);
    lat = 0;
    while (!valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    e = exp_q.pop_front();
    check("p_m", p_m, e[3:0]);
    check("sf", sf, e[4]);
    check("zf", zf, e[5]);
    if (do_ack) begin
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_valid", valid, 0);
      check("ack_ready", ready, 1);
    end
  endtask

  // Drive one request into the MAG_W=4 instance; returns edges from accept to idle.
  task automatic run_op4(input bit as_, input logic [3:0] am, input bit bs_,
                         input logic [3:0] bm, input logic [7:0] exp_p,
                         input bit exp_s, output int busy);
    int n;
    a_s4 = as_; a_m4 = am; b_s4 = bs_; b_m4 = bm;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    while (!valid4 && n < 30) begin
      tick();
      n++;
    end
    check("w4_latency", n, 5);
    check("w4_p_m", p_m4, exp_p);
    check("w4_sf", sf4, exp_s);
    check("w4_zf", zf4, 0);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    n++;
    check("w4_ready", ready4, 1);
    busy = n;
  endtask

  initial begin
    int busy;
    rst_n = 1'b0;
    start = 0; a_s = 0; a_m = 0; b_s = 0; b_m = 0; ack = 0;
    start4 = 0; a_s4 = 0; a_m4 = 0; b_s4 = 0; b_m4 = 0; ack4 = 0;
    tick(); tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_valid", valid, 0);
    check("rst_p_m", p_m, 0);
    check("rst_sf", sf, 0);
    check("rst_zf", zf, 0);
    rst_n = 1'b1;
    tick();

    // ack with nothing pending is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_ready", ready, 1);
    check("idle_ack_valid", valid, 0);

    run_op(1'b1, 2'd3, 1'b0, 2'd2, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
    run_op(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    run_op(1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);

    // result held without ack; start during DONE must not queue a second op
    run_op(1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_s = 1'b0; a_m = 2'd1; b_s = 1'b0; b_m = 2'd1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      check("hold_valid", valid, 1);
      check("hold_p_m", p_m, 9);
      check("hold_sf", sf, 0);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("hold_ack_valid", valid, 0);
    for (int i = 0; i < 6; i++) tick();
    check("no_second_valid", valid, 0);
    check("no_second_ready", ready, 1);

    // operands change after accept
    run_op(1'b0, 2'd1, 1'b0, 2'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);

    // asynchronous reset mid-RUN
    a_s = 1'b0; a_m = 2'd3; b_s = 1'b0; b_m = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_ready", ready, 1);
    check("arst_p_m", p_m, 0);
    check("arst_sf", sf, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_op(1'b0, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0);

    // wide instance: max product, then back-to-back ops
    run_op4(1'b0, 4'd15, 1'b1, 4'd15, 8'd225, 1'b1, busy);
    run_op4(1'b0, 4'd5, 1'b0, 4'd3, 8'd15, 1'b0, busy);
    check("w4_busy_a", busy, 6);
    run_op4(1'b1, 4'd7, 1'b0, 4'd9, 8'd63, 1'b1, busy);
    check("w4_busy_b", busy, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
